// File: rtl/connect4_pkg.sv
// Shared Connect-4 types and constants for the move controller slice.
package connect4_pkg;
  localparam int COLS_DEF = 7;
  localparam int ROWS_DEF = 6;

  localparam int LRP_LEFT  = 2;
  localparam int LRP_RIGHT = 1;
  localparam int LRP_PUT   = 0;

  typedef enum logic [1:0] {PLAY = 2'd0, DROP = 2'd1, FULL = 2'd2} state_t;
  typedef enum logic {SELF = 1'b0, OPP = 1'b1} player_t;
endpackage

// File: rtl/column_height_tracker.sv
// Per-column fill heights; increment lands one cycle after inc, sel_height is combinational.
// No backpressure: clr wins over inc, callers never increment a full column.
module column_height_tracker
  import connect4_pkg::*;
#(
  parameter int COLS = COLS_DEF,
  parameter int ROWS = ROWS_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      inc,
  input  logic [$clog2(COLS)-1:0]   inc_col,
  input  logic [$clog2(COLS)-1:0]   sel_col,
  output logic [$clog2(ROWS+1)-1:0] sel_height,
  output logic [COLS-1:0]           col_full
);
  localparam int HGT_W = $clog2(ROWS+1);

  logic [HGT_W-1:0] height_q [COLS];
  logic [HGT_W-1:0] height_d [COLS];

  always_comb begin
    height_d = height_q;
    if (clr) begin
      for (int i = 0; i < COLS; i++) height_d[i] = '0;
    end else if (inc) begin
      height_d[inc_col] = height_q[inc_col] + HGT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < COLS; i++) height_q[i] <= '0;
    end else begin
      height_q <= height_d;
    end
  end

  assign sel_height = height_q[sel_col];

  for (genvar g = 0; g < COLS; g++) begin : g_full
    assign col_full[g] = (height_q[g] == HGT_W'(ROWS));
  end
endmodule

// File: rtl/move_controller.sv
// Cursor, turn and board owner for Connect-4; a put lands on the board two edges after its pulse.
// No backpressure: pulses arriving in DROP/FULL or from the idle player are dropped.
module move_controller
  import connect4_pkg::*;
#(
  parameter int COLS = COLS_DEF,
  parameter int ROWS = ROWS_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    self_first,
  input  logic [2:0]              lrp_self,
  input  logic [2:0]              lrp_opponent,
  output logic [$clog2(COLS)-1:0] cursor_col,
  output logic                    turn,
  output logic [ROWS*COLS-1:0]    board_self,
  output logic [ROWS*COLS-1:0]    board_opp,
  output logic                    drop_valid,
  output logic [$clog2(ROWS)-1:0] drop_row,
  output logic [$clog2(COLS)-1:0] drop_col,
  output logic                    illegal_put,
  output logic                    game_full
);
  localparam int CUR_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);
  localparam int HGT_W = $clog2(ROWS+1);
  localparam int CELLS = ROWS*COLS;
  localparam int CNT_W = $clog2(CELLS+1);
  localparam int IDX_W = $clog2(CELLS);
  localparam logic [CUR_W-1:0] MID_COL = CUR_W'(COLS/2);

  state_t           state_q, state_d;
  logic [CUR_W-1:0] cursor_q, cursor_d;
  logic             turn_q, turn_d;
  logic [CELLS-1:0] board_self_q, board_self_d, board_opp_q, board_opp_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CUR_W-1:0] pend_col_q, pend_col_d;
  logic [ROW_W-1:0] pend_row_q, pend_row_d;
  logic [CUR_W-1:0] drop_col_q, drop_col_d;
  logic [ROW_W-1:0] drop_row_q, drop_row_d;
  logic             drop_valid_q, drop_valid_d, illegal_q, illegal_d;

  logic [2:0]       lrp;
  logic [HGT_W-1:0] sel_height;
  logic [COLS-1:0]  col_full;
  logic [IDX_W-1:0] drop_idx;
  logic             commit;

  assign commit   = (state_q == DROP) && !start;
  assign drop_idx = IDX_W'(pend_row_q) * IDX_W'(COLS) + IDX_W'(pend_col_q);

  column_height_tracker #(.COLS(COLS), .ROWS(ROWS)) u_heights (
    .clk        (clk),
    .rst        (rst),
    .clr        (start),
    .inc        (commit),
    .inc_col    (pend_col_q),
    .sel_col    (cursor_q),
    .sel_height (sel_height),
    .col_full   (col_full)
  );

  always_comb begin
    lrp          = (turn_q == OPP) ? lrp_opponent : lrp_self;
    state_d      = state_q;
    cursor_d     = cursor_q;
    turn_d       = turn_q;
    board_self_d = board_self_q;
    board_opp_d  = board_opp_q;
    count_d      = count_q;
    pend_col_d   = pend_col_q;
    pend_row_d   = pend_row_q;
    drop_col_d   = drop_col_q;
    drop_row_d   = drop_row_q;
    drop_valid_d = 1'b0;
    illegal_d    = 1'b0;

    case (state_q)
      PLAY: begin
        if (lrp[LRP_LEFT]) begin
          cursor_d = (cursor_q == '0) ? CUR_W'(COLS-1) : cursor_q - CUR_W'(1);
        end else if (lrp[LRP_RIGHT]) begin
          cursor_d = (cursor_q == CUR_W'(COLS-1)) ? '0 : cursor_q + CUR_W'(1);
        end else if (lrp[LRP_PUT]) begin
          if (col_full[cursor_q]) begin
            illegal_d = 1'b1;
          end else begin
            pend_col_d = cursor_q;
            pend_row_d = sel_height[ROW_W-1:0];
            state_d    = DROP;
          end
        end
      end
      DROP: begin
        if (turn_q == OPP) board_opp_d[drop_idx] = 1'b1;
        else               board_self_d[drop_idx] = 1'b1;
        count_d      = count_q + CNT_W'(1);
        drop_valid_d = 1'b1;
        drop_row_d   = pend_row_q;
        drop_col_d   = pend_col_q;
        turn_d       = ~turn_q;
        cursor_d     = MID_COL;
        state_d      = (count_d == CNT_W'(CELLS)) ? FULL : PLAY;
      end
      default: ;
    endcase

    // A new game aborts whatever is in flight, including an uncommitted drop.
    if (start) begin
      state_d      = PLAY;
      cursor_d     = MID_COL;
      turn_d       = ~self_first;
      board_self_d = '0;
      board_opp_d  = '0;
      count_d      = '0;
      drop_valid_d = 1'b0;
      illegal_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= PLAY;
      cursor_q     <= MID_COL;
      turn_q       <= ~self_first;
      board_self_q <= '0;
      board_opp_q  <= '0;
      count_q      <= '0;
      pend_col_q   <= '0;
      pend_row_q   <= '0;
      drop_col_q   <= '0;
      drop_row_q   <= '0;
      drop_valid_q <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cursor_q     <= cursor_d;
      turn_q       <= turn_d;
      board_self_q <= board_self_d;
      board_opp_q  <= board_opp_d;
      count_q      <= count_d;
      pend_col_q   <= pend_col_d;
      pend_row_q   <= pend_row_d;
      drop_col_q   <= drop_col_d;
      drop_row_q   <= drop_row_d;
      drop_valid_q <= drop_valid_d;
      illegal_q    <= illegal_d;
    end
  end

  assign cursor_col  = cursor_q;
  assign turn        = turn_q;
  assign board_self  = board_self_q;
  assign board_opp   = board_opp_q;
  assign drop_valid  = drop_valid_q;
  assign drop_row    = drop_row_q;
  assign drop_col    = drop_col_q;
  assign illegal_put = illegal_q;
  assign game_full   = (state_q == FULL);
endmodule

// File: tb/tb_move_controller.sv
// Directed bench for move_controller: cursor wrap, turn gating, drops, full column/board, start abort.
module tb_move_controller;
  localparam int CELLS = 42;
  localparam logic [2:0] L = 3'b100;
  localparam logic [2:0] R = 3'b010;
  localparam logic [2:0] P = 3'b001;

  logic clk = 1'b0;
  logic rst, start, self_first;
  logic [2:0] lrp_self, lrp_opponent;
  logic [2:0] cursor_col;
  logic turn;
  logic [CELLS-1:0] board_self, board_opp;
  logic drop_valid;
  logic [2:0] drop_row, drop_col;
  logic illegal_put, game_full;

  int errors = 0;
  int checks = 0;

  logic [CELLS-1:0] exp_self, exp_opp;
  int   exp_h [7];
  logic exp_turn;
  int   exp_cnt;

  always #5 clk = ~clk;

  move_controller dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .self_first   (self_first),
    .lrp_self     (lrp_self),
    .lrp_opponent (lrp_opponent),
    .cursor_col   (cursor_col),
    .turn         (turn),
    .board_self   (board_self),
    .board_opp    (board_opp),
    .drop_valid   (drop_valid),
    .drop_row     (drop_row),
    .drop_col     (drop_col),
    .illegal_put  (illegal_put),
    .game_full    (game_full)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  // One-cycle pulse; returns at the negedge after the sampling posedge.
  task automatic pulse(input logic [2:0] s, input logic [2:0] o);
    @(negedge clk);
    lrp_self = s;
    lrp_opponent = o;
    @(negedge clk);
    lrp_self = 3'b000;
    lrp_opponent = 3'b000;
  endtask

  task automatic active(input logic [2:0] v);
    if (exp_turn) pulse(3'b000, v);
    else pulse(v, 3'b000);
  endtask

  task automatic model_clear();
    exp_self = '0;
    exp_opp  = '0;
    for (int i = 0; i < 7; i++) exp_h[i] = 0;
    exp_turn = ~self_first;
    exp_cnt  = 0;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    model_clear();
  endtask

  // Legal put into col by the active player, starting with cursor at 3.
  task automatic do_put(input int col);
    int idx;
    logic [2:0] exp_row;
    for (int m = col; m < 3; m++) active(L);
    for (int m = 3; m < col; m++) active(R);
    active(P);
    checks++;
    if (drop_valid !== 1'b0 || board_self !== exp_self || board_opp !== exp_opp) begin
      errors++;
      $display("FAIL put_early col=%0d: drop_valid=%b self=%h opp=%h, required 0 %h %h",
               col, drop_valid, board_self, board_opp, exp_self, exp_opp);
    end
    tick();
    exp_row = 3'(exp_h[col]);
    idx = exp_h[col] * 7 + col;
    if (exp_turn) exp_opp[idx] = 1'b1;
    else exp_self[idx] = 1'b1;
    exp_h[col]++;
    exp_cnt++;
    exp_turn = ~exp_turn;
    checks++;
    if (drop_valid !== 1'b1 || drop_row !== exp_row || drop_col !== 3'(col)) begin
      errors++;
      $display("FAIL put_drop col=%0d: valid=%b row=%0d col=%0d, required 1 %0d %0d",
               col, drop_valid, drop_row, drop_col, exp_row, col);
    end
    checks++;
    if (board_self !== exp_self || board_opp !== exp_opp) begin
      errors++;
      $display("FAIL put_board col=%0d: self=%h opp=%h, required %h %h",
               col, board_self, board_opp, exp_self, exp_opp);
    end
    checks++;
    if (turn !== exp_turn || cursor_col !== 3'd3 || game_full !== (exp_cnt == CELLS)) begin
      errors++;
      $display("FAIL put_state col=%0d: turn=%b cursor=%0d full=%b, required %b 3 %b",
               col, turn, cursor_col, game_full, exp_turn, exp_cnt == CELLS);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; self_first = 1'b1;
    lrp_self = 3'b000; lrp_opponent = 3'b000;
    repeat (3) tick();
    rst = 1'b0;
    model_clear();
    tick();
    checks++;
    if (cursor_col !== 3'd3 || turn !== 1'b0 || game_full !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl: cursor=%0d turn=%b full=%b, required 3 0 0", cursor_col, turn, game_full);
    end
    checks++;
    if (board_self !== '0 || board_opp !== '0) begin
      errors++;
      $display("FAIL reset_board: self=%h opp=%h, required 0 0", board_self, board_opp);
    end
    checks++;
    if (drop_valid !== 1'b0 || illegal_put !== 1'b0 || drop_row !== 3'd0 || drop_col !== 3'd0) begin
      errors++;
      $display("FAIL reset_drop: valid=%b illegal=%b row=%0d col=%0d, required 0 0 0 0",
               drop_valid, illegal_put, drop_row, drop_col);
    end
  endtask

  task automatic test_cursor_wrap();
    logic [2:0] exp_cur [5];
    exp_cur[0] = 3'd2; exp_cur[1] = 3'd1; exp_cur[2] = 3'd0; exp_cur[3] = 3'd6; exp_cur[4] = 3'd0;
    for (int i = 0; i < 5; i++) begin
      pulse(i == 4 ? R : L, 3'b000);
      checks++;
      if (cursor_col !== exp_cur[i] || turn !== 1'b0) begin
        errors++;
        $display("FAIL cursor_step%0d: cursor=%0d turn=%b, required %0d 0", i, cursor_col, turn, exp_cur[i]);
      end
    end
    repeat (3) pulse(R, 3'b000);
    checks++;
    if (cursor_col !== 3'd3) begin
      errors++;
      $display("FAIL cursor_return: cursor=%0d, required 3", cursor_col);
    end
  endtask

  task automatic test_inactive_ignored();
    pulse(3'b000, P);
    tick();
    pulse(3'b000, L);
    checks++;
    if (drop_valid !== 1'b0 || board_self !== '0 || board_opp !== '0) begin
      errors++;
      $display("FAIL inactive_board: valid=%b self=%h opp=%h, required 0 0 0", drop_valid, board_self, board_opp);
    end
    tick();
    checks++;
    if (drop_valid !== 1'b0 || turn !== 1'b0 || cursor_col !== 3'd3) begin
      errors++;
      $display("FAIL inactive_ctl: valid=%b turn=%b cursor=%0d, required 0 0 3", drop_valid, turn, cursor_col);
    end
  endtask

  task automatic test_drop();
    do_put(3);
    tick();
    checks++;
    if (drop_valid !== 1'b0 || drop_row !== 3'd0 || drop_col !== 3'd3) begin
      errors++;
      $display("FAIL drop_hold: valid=%b row=%0d col=%0d, required 0 0 3", drop_valid, drop_row, drop_col);
    end
    do_put(3);
    checks++;
    if (board_opp[10] !== 1'b1 || drop_row !== 3'd1) begin
      errors++;
      $display("FAIL drop_stack: opp10=%b row=%0d, required 1 1", board_opp[10], drop_row);
    end
  endtask

  task automatic test_column_full();
    repeat (6) do_put(0);
    repeat (3) active(L);
    active(P);
    checks++;
    if (illegal_put !== 1'b1 || cursor_col !== 3'd0) begin
      errors++;
      $display("FAIL illegal_pulse: illegal=%b cursor=%0d, required 1 0", illegal_put, cursor_col);
    end
    tick();
    checks++;
    if (illegal_put !== 1'b0 || drop_valid !== 1'b0 || turn !== exp_turn) begin
      errors++;
      $display("FAIL illegal_after: illegal=%b valid=%b turn=%b, required 0 0 %b",
               illegal_put, drop_valid, turn, exp_turn);
    end
    checks++;
    if (board_self !== exp_self || board_opp !== exp_opp) begin
      errors++;
      $display("FAIL illegal_board: self=%h opp=%h, required %h %h", board_self, board_opp, exp_self, exp_opp);
    end
  endtask

  task automatic test_fill_board();
    do_start();
    tick();
    checks++;
    if (board_self !== '0 || board_opp !== '0 || turn !== 1'b0 || cursor_col !== 3'd3) begin
      errors++;
      $display("FAIL start_clear: self=%h opp=%h turn=%b cursor=%0d, required 0 0 0 3",
               board_self, board_opp, turn, cursor_col);
    end
    for (int c = 0; c < 7; c++) repeat (6) do_put(c);
    pulse(L, L);
    pulse(P, P);
    tick();
    checks++;
    if (game_full !== 1'b1 || drop_valid !== 1'b0 || cursor_col !== 3'd3 ||
        board_self !== exp_self || board_opp !== exp_opp) begin
      errors++;
      $display("FAIL full_ignore: full=%b valid=%b cursor=%0d self=%h opp=%h, required 1 0 3 %h %h",
               game_full, drop_valid, cursor_col, board_self, board_opp, exp_self, exp_opp);
    end
    self_first = 1'b0;
    do_start();
    checks++;
    if (game_full !== 1'b0 || board_self !== '0 || board_opp !== '0 || turn !== 1'b1) begin
      errors++;
      $display("FAIL full_restart: full=%b self=%h opp=%h turn=%b, required 0 0 0 1",
               game_full, board_self, board_opp, turn);
    end
  endtask

  task automatic test_left_put_priority();
    active(L | P);
    checks++;
    if (cursor_col !== 3'd2 || illegal_put !== 1'b0) begin
      errors++;
      $display("FAIL prio_cursor: cursor=%0d illegal=%b, required 2 0", cursor_col, illegal_put);
    end
    tick();
    checks++;
    if (drop_valid !== 1'b0 || board_opp !== '0 || board_self !== '0 || turn !== 1'b1) begin
      errors++;
      $display("FAIL prio_nodrop: valid=%b self=%h opp=%h turn=%b, required 0 0 0 1",
               drop_valid, board_self, board_opp, turn);
    end
  endtask

  task automatic test_start_in_drop();
    self_first = 1'b1;
    @(negedge clk);
    lrp_opponent = P;
    @(negedge clk);
    lrp_opponent = 3'b000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    model_clear();
    checks++;
    if (drop_valid !== 1'b0 || board_self !== '0 || board_opp !== '0) begin
      errors++;
      $display("FAIL abort_board: valid=%b self=%h opp=%h, required 0 0 0", drop_valid, board_self, board_opp);
    end
    checks++;
    if (turn !== 1'b0 || cursor_col !== 3'd3 || game_full !== 1'b0) begin
      errors++;
      $display("FAIL abort_ctl: turn=%b cursor=%0d full=%b, required 0 3 0", turn, cursor_col, game_full);
    end
    tick();
    checks++;
    if (drop_valid !== 1'b0 || board_opp !== '0) begin
      errors++;
      $display("FAIL abort_late: valid=%b opp=%h, required 0 0", drop_valid, board_opp);
    end
    do_put(2);
  endtask

  initial begin
    test_reset();
    test_cursor_wrap();
    test_inactive_ignored();
    test_drop();
    test_column_full();
    test_fill_board();
    test_left_put_priority();
    test_start_in_drop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/move_controller.md
Name: move_controller

Overview:
- Consumes the one-hot left/right/put pulse vectors from the input stage: local player (lrp_self) and remote player (lrp_opponent).
- Keeps the shared column cursor and turn ownership, drops pieces into the lowest free row, and holds both players' board occupancy.
- Feeds the display and win-check stages downstream.

Parameters:
COLS, 7, board width in columns (cursor width = $clog2(COLS))
ROWS, 6, board height in rows (height counter width = $clog2(ROWS+1))

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  single-cycle pulse: clear the board and begin a new game
self_first  in  1  sampled at rst/start: 1 = local player moves first
lrp_self  in  3  local pulses; [2]=left, [1]=right, [0]=put
lrp_opponent  in  3  remote pulses, same encoding
cursor_col  out  $clog2(COLS)  current cursor column, 0 = leftmost
turn  out  1  0 = local player to move, 1 = opponent to move
board_self  out  ROWS*COLS  local piece map; bit index = row*COLS+col, row 0 = bottom
board_opp  out  ROWS*COLS  opponent piece map, same indexing
drop_valid  out  1  1-cycle pulse when a piece is written
drop_row  out  $clog2(ROWS)  row of the last drop (held until the next drop)
drop_col  out  $clog2(COLS)  column of the last drop (held)
illegal_put  out  1  1-cycle pulse: put into a full column
game_full  out  1  high while the board is full

Behaviour:
- Reset values: cursor_col = COLS/2 (3); turn = ~self_first; boards = 0; heights = 0; drop_valid = 0; illegal_put = 0; drop_row = 0; drop_col = 0; game_full = 0; state = PLAY.
- States:
  - PLAY: accepts moves.
  - DROP: one-cycle board write.
  - FULL: game over.
- Active vector: lrp_self when turn = 0, lrp_opponent when turn = 1. The inactive player's vector is ignored entirely.
- Multiple bits set in the active vector: priority left > right > put.
- PLAY, left: cursor_col decrements; 0 wraps to COLS-1. Visible the cycle after the pulse.
- PLAY, right: cursor_col increments; COLS-1 wraps to 0.
- PLAY, put with height[cursor_col] < ROWS: latch column and row = height[cursor_col]; go to DROP.
- PLAY, put with height[cursor_col] = ROWS: illegal_put pulses the next cycle; stay in PLAY; turn unchanged.
- DROP (exactly one cycle):
  - Set the current player's board bit; increment height[col].
  - Drive drop_row/drop_col; drop_valid = 1 the following cycle.
  - Toggle turn; cursor_col returns to COLS/2.
  - Next state: FULL if the piece count reaches ROWS*COLS, else PLAY.
  - All lrp inputs are ignored during DROP.
- Latency: put pulse at edge t → DROP at t+1 → board, turn and drop_valid updated at edge t+2.
- FULL: game_full = 1; all lrp inputs are ignored; only start or rst leaves FULL.
- start (any state, including mid-DROP): takes priority over all lrp inputs.
  - Clears boards, heights and piece count; cursor_col = COLS/2; turn = ~self_first.
  - Aborts any pending drop: no board write, no drop_valid.
  - Next state: PLAY.
- rst has priority over start.
- Invariant: board_self & board_opp == 0 at all times. A set bit at row r>0 implies bit r-1 of the same column is set.
- Piece counter width: $clog2(ROWS*COLS+1). It never wraps.

Decomposition:
- connect4_pkg holds:
  - COLS, ROWS defaults.
  - LRP_LEFT=2, LRP_RIGHT=1, LRP_PUT=0 bit indices.
  - state_t enum {PLAY, DROP, FULL}.
  - player_t enum {SELF=0, OPP=1}.
- Sub-module column_height_tracker owns:
  - Per-column height registers with clear, increment, and full flag per column.
  - It is parameterised by COLS/ROWS and returns height[col] combinationally for the selected column.

Test Plan:
- Reset with self_first=1, then 3 lrp_self left pulses:
  - Expect turn=0 and cursor 3→2→1→0.
  - A 4th left pulse wraps cursor_col to 6.
- turn=0, lrp_opponent put pulses at col 3 → no board change, no drop_valid, turn stays 0.
- Local put at col 3:
  - Expect drop_valid exactly 2 cycles after the pulse, drop_row=0, drop_col=3.
  - Expect board_self bit 3 set, turn=1, cursor_col=3.
  - A following opponent put at col 3 gives drop_row=1 and board_opp bit 10 set.
- Alternate puts into col 0 until 6 pieces are stacked; a 7th put → illegal_put pulse, boards unchanged, turn unchanged.
- Fill all 42 cells with legal alternating moves:
  - Expect game_full=1 after the last drop; further pulses are ignored.
  - A start pulse clears the boards, game_full=0, turn=~self_first.
- Simultaneous left+put on the active vector → cursor moves left, no drop.
- start asserted in the DROP cycle → no piece written, no drop_valid, boards=0.
